// File: rtl/mat_mult_stream.sv
// Streaming matrix multiplier C[MxN] = A[MxK] * B[KxN], element-serial in and out.
// Define MAT_MULT_SIGNED_EN for two's complement operands and results.
module mat_mult_stream #(
    parameter  int M      = 3,
    parameter  int K      = 3,
    parameter  int N      = 3,
    parameter  int DATA_W = 4,
    localparam int OUT_W  = 2*DATA_W + $clog2(K) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_row_last,
    output logic              out_last,
    output logic              busy
);

    localparam int A_EL  = M*K;
    localparam int B_EL  = K*N;
    localparam int MAXE  = (A_EL > B_EL) ? A_EL : B_EL;
    localparam int CNT_W = (MAXE > 1) ? $clog2(MAXE) : 1;
    localparam int A_IW  = (A_EL > 1) ? $clog2(A_EL) : 1;
    localparam int B_IW  = (B_EL > 1) ? $clog2(B_EL) : 1;
    localparam int ROW_W = (M > 1) ? $clog2(M) : 1;
    localparam int K_W   = (K > 1) ? $clog2(K) : 1;
    localparam int J_W   = (N > 1) ? $clog2(N) : 1;
    localparam int P_W   = 2*DATA_W;

    localparam logic [CNT_W-1:0] A_LAST   = CNT_W'(A_EL - 1);
    localparam logic [CNT_W-1:0] B_LAST   = CNT_W'(B_EL - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(M - 1);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(K - 1);
    localparam logic [J_W-1:0]   J_LAST   = J_W'(N - 1);

    typedef enum logic [1:0] {LOAD_A, LOAD_B, COMPUTE, OUTPUT} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ROW_W-1:0]  r_row;
    logic [K_W-1:0]    r_k;
    logic [J_W-1:0]    r_j;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_a   [A_EL];
    logic [DATA_W-1:0] r_b   [B_EL];
    logic [OUT_W-1:0]  r_acc [N];

    logic              w_in_fire;
    logic              w_out_fire;
    logic [A_IW-1:0]   w_a_idx;
    logic [B_IW-1:0]   w_b_idx [N];
    logic [P_W-1:0]    w_mul   [N];
    logic [OUT_W-1:0]  w_prod  [N];

    assign w_in_fire    = in_valid && r_in_ready;
    assign w_out_fire   = out_valid && out_ready;
    assign in_ready     = r_in_ready;
    assign out_valid    = (r_state == OUTPUT);
    assign out_data     = out_valid ? r_acc[r_j] : '0;
    assign out_row_last = out_valid && (r_j == J_LAST);
    assign out_last     = out_valid && (r_j == J_LAST) && (r_row == ROW_LAST);
    assign busy         = (r_state != LOAD_A) || (r_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            LOAD_A:  if (w_in_fire && r_cnt == A_LAST) w_next_state = LOAD_B;
            LOAD_B:  if (w_in_fire && r_cnt == B_LAST) w_next_state = COMPUTE;
            COMPUTE: if (r_k == K_LAST) w_next_state = OUTPUT;
            OUTPUT: begin
                if (w_out_fire && r_j == J_LAST) begin
                    w_next_state = (r_row == ROW_LAST) ? LOAD_A : COMPUTE;
                end
            end
            default: w_next_state = LOAD_A;
        endcase
    end

    // Counters; in_ready is registered from the next state so it drops right after the last B beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_row      <= '0;
            r_k        <= '0;
            r_j        <= '0;
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= (w_next_state == LOAD_A) || (w_next_state == LOAD_B);
            case (r_state)
                LOAD_A: if (w_in_fire) r_cnt <= (r_cnt == A_LAST) ? '0 : r_cnt + 1'b1;
                LOAD_B: if (w_in_fire) r_cnt <= (r_cnt == B_LAST) ? '0 : r_cnt + 1'b1;
                COMPUTE: r_k <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
                OUTPUT: begin
                    if (w_out_fire) begin
                        r_j <= (r_j == J_LAST) ? '0 : r_j + 1'b1;
                        if (r_j == J_LAST) r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (r_state == LOAD_A && w_in_fire) r_a[A_IW'(r_cnt)] <= in_data;
        if (r_state == LOAD_B && w_in_fire) r_b[B_IW'(r_cnt)] <= in_data;
    end

    always_comb begin
        w_a_idx = A_IW'(int'(r_row) * K + int'(r_k));
        for (int j = 0; j < N; j++) begin
            w_b_idx[j] = B_IW'(int'(r_k) * N + j);
`ifdef MAT_MULT_SIGNED_EN
            w_mul[j]  = P_W'($signed(r_a[w_a_idx])) * P_W'($signed(r_b[w_b_idx[j]]));
            w_prod[j] = OUT_W'($signed(w_mul[j]));
`else
            w_mul[j]  = P_W'(r_a[w_a_idx]) * P_W'(r_b[w_b_idx[j]]);
            w_prod[j] = OUT_W'(w_mul[j]);
`endif
        end
    end

    // The first k step overwrites the accumulators, which clears them on entry to each row.
    always_ff @(posedge clk) begin
        if (!rst && r_state == COMPUTE) begin
            for (int j = 0; j < N; j++) begin
                r_acc[j] <= ((r_k == '0) ? '0 : r_acc[j]) + w_prod[j];
            end
        end
    end

endmodule

// File: tb/tb_mat_mult_stream.sv
// Scoreboard bench for mat_mult_stream: a 3x3x3 instance and a 2x4x1 instance.
// The reference model follows MAT_MULT_SIGNED_EN, so the same steps work in both modes.
module tb_mat_mult_stream;

    localparam int DATA_W = 4;
    localparam int OUT_W  = 11;
    localparam int MASK   = (1 << OUT_W) - 1;

    typedef struct {
        int data;
        bit rowLast;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [DATA_W-1:0] in_data = '0;
    logic out_ready = 1'b0;
    logic in_valid0 = 1'b0, in_valid1 = 1'b0;
    logic in_ready0, in_ready1, out_valid0, out_valid1;
    logic out_row_last0, out_row_last1, out_last0, out_last1, busy0, busy1;
    logic [OUT_W-1:0] out_data0, out_data1;

    int nCmp = 0;
    int nErr = 0;
    int cyc = 0;
    int lastBeatCyc = 0;
    int stim[$];
    int qa[$];
    int qb[$];
    exp_t sb0[$];
    exp_t sb1[$];

    mat_mult_stream #(.M(3), .K(3), .N(3), .DATA_W(DATA_W)) u0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid0), .in_ready(in_ready0),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
        .out_row_last(out_row_last0), .out_last(out_last0), .busy(busy0)
    );

    mat_mult_stream #(.M(2), .K(4), .N(1), .DATA_W(DATA_W)) u1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid1), .in_ready(in_ready1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
        .out_row_last(out_row_last1), .out_last(out_last1), .busy(busy1)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endfunction

    function automatic int sx(input int v);
`ifdef MAT_MULT_SIGNED_EN
        return (v >= 8) ? v - 16 : v;
`else
        return v;
`endif
    endfunction

    // Output monitors: every valid cycle is compared to the scoreboard head, so stalled beats must hold.
    always @(negedge clk) begin
        if (out_valid0) begin
            if (sb0.size() == 0) begin
                checkOutput("u0_extra_beat", 32'(out_valid0), 0);
            end else begin
                checkOutput("u0_data", 32'(out_data0), sb0[0].data);
                checkOutput("u0_row_last", 32'(out_row_last0), 32'(sb0[0].rowLast));
                checkOutput("u0_last", 32'(out_last0), 32'(sb0[0].last));
                if (out_ready) void'(sb0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (out_valid1) begin
            if (sb1.size() == 0) begin
                checkOutput("u1_extra_beat", 32'(out_valid1), 0);
            end else begin
                checkOutput("u1_data", 32'(out_data1), sb1[0].data);
                checkOutput("u1_row_last", 32'(out_row_last1), 32'(sb1[0].rowLast));
                checkOutput("u1_last", 32'(out_last1), 32'(sb1[0].last));
                if (out_ready) void'(sb1.pop_front());
            end
        end
    end

    task automatic loadFrame(input int dut, input int m, input int k, input int n);
        exp_t e;
        int s;
        stim.delete();
        foreach (qa[i]) stim.push_back(qa[i]);
        foreach (qb[i]) stim.push_back(qb[i]);
        for (int i = 0; i < m; i++) begin
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int kk = 0; kk < k; kk++) s += sx(qa[i*k + kk]) * sx(qb[kk*n + j]);
                e.data    = s & MASK;
                e.rowLast = (j == n - 1);
                e.last    = (i == m - 1) && (j == n - 1);
                if (dut == 0) sb0.push_back(e);
                else sb1.push_back(e);
            end
        end
    endtask

    task automatic driveValid(input int dut, input logic v);
        if (dut == 0) in_valid0 = v;
        else in_valid1 = v;
    endtask

    task automatic applyStimulus(input int dut, input bit gaps);
        logic rdy;
        for (int i = 0; i < stim.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                driveValid(dut, 1'b0);
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            in_data = DATA_W'(stim[i]);
            driveValid(dut, 1'b1);
            rdy = 1'b0;
            for (int t = 0; t < 50 && !rdy; t++) begin
                @(negedge clk);
                rdy = (dut == 0) ? in_ready0 : in_ready1;
            end
            if (!rdy) begin
                checkOutput("accept_timeout", 32'(rdy), 1);
                break;
            end
            lastBeatCyc = cyc;
            @(posedge clk);
            #1;
        end
        driveValid(dut, 1'b0);
    endtask

    task automatic drainOutputs(input int dut, input bit toggle);
        bit [3:0] pat = 4'b1001;
        int left;
        for (int t = 0; t < 400; t++) begin
            left = (dut == 0) ? sb0.size() : sb1.size();
            if (left == 0) break;
            out_ready = toggle ? pat[t % 4] : 1'b1;
            @(posedge clk);
            #1;
        end
        left = (dut == 0) ? sb0.size() : sb1.size();
        checkOutput("drain_left", left, 0);
        checkOutput("valid_after_frame", 32'((dut == 0) ? out_valid0 : out_valid1), 0);
        checkOutput("busy_after_frame", 32'((dut == 0) ? busy0 : busy1), 0);
        checkOutput("ready_after_frame", 32'((dut == 0) ? in_ready0 : in_ready1), 1);
    endtask

    task automatic setIdentityTimesSeq();
        qa.delete();
        qb.delete();
        for (int i = 0; i < 9; i++) begin
            qa.push_back((i % 4 == 0) ? 1 : 0);
            qb.push_back(i + 1);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(in_ready0), 0);
        checkOutput({tag, "_out_valid"}, 32'(out_valid0), 0);
        checkOutput({tag, "_out_data"}, 32'(out_data0), 0);
        checkOutput({tag, "_row_last"}, 32'(out_row_last0), 0);
        checkOutput({tag, "_last"}, 32'(out_last0), 0);
        checkOutput({tag, "_busy"}, 32'(busy0), 0);
    endtask

    initial begin
        bit seen;
        $display("[TB] reset");
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rst = 1'b0;
        checkOutput("ready_before_first_edge", 32'(in_ready0), 0);
        @(posedge clk);
        #1;
        checkOutput("ready_after_reset", 32'(in_ready0), 1);
        checkOutput("idle_busy", 32'(busy0), 0);

        $display("[TB] identity x 1..9, latency, ignored input outside load");
        setIdentityTimesSeq();
        loadFrame(0, 3, 3, 3);
        out_ready = 1'b1;
        applyStimulus(0, 1'b0);
        in_data   = 4'd7;
        in_valid0 = 1'b1;
        checkOutput("ready_in_compute", 32'(in_ready0), 0);
        checkOutput("busy_in_compute", 32'(busy0), 1);
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            seen = out_valid0;
        end
        checkOutput("first_valid_latency", cyc - lastBeatCyc, 4);
        in_valid0 = 1'b0;
        drainOutputs(0, 1'b0);

        $display("[TB] identity x 1..9 with input gaps and output backpressure");
        setIdentityTimesSeq();
        loadFrame(0, 3, 3, 3);
        applyStimulus(0, 1'b1);
        drainOutputs(0, 1'b1);

        $display("[TB] reset during output");
        setIdentityTimesSeq();
        loadFrame(0, 3, 3, 3);
        applyStimulus(0, 1'b0);
        out_ready = 1'b1;
        for (int t = 0; t < 100; t++) begin
            if (sb0.size() == 5) break;
            @(posedge clk);
            #1;
        end
        checkOutput("beats_before_reset", sb0.size(), 5);
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkResetOutputs("midrst");
        sb0.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ready_after_midrst", 32'(in_ready0), 1);

        $display("[TB] all operands 15");
        qa.delete();
        qb.delete();
        for (int i = 0; i < 9; i++) begin
            qa.push_back(15);
            qb.push_back(15);
        end
        loadFrame(0, 3, 3, 3);
        applyStimulus(0, 1'b0);
        drainOutputs(0, 1'b0);

        $display("[TB] 2x4x1 instance");
        qa.delete();
        qb.delete();
        for (int i = 0; i < 8; i++) qa.push_back(i + 1);
        for (int i = 0; i < 4; i++) qb.push_back(1);
        loadFrame(1, 2, 4, 1);
        applyStimulus(1, 1'b0);
        drainOutputs(1, 1'b0);

        $display("[TB] operand patterns 8 x 15 and 8 x 8");
        qa.delete();
        qb.delete();
        for (int i = 0; i < 9; i++) begin
            qa.push_back(8);
            qb.push_back(15);
        end
        loadFrame(0, 3, 3, 3);
        applyStimulus(0, 1'b0);
        drainOutputs(0, 1'b0);
        qb.delete();
        for (int i = 0; i < 9; i++) qb.push_back(8);
        loadFrame(0, 3, 3, 3);
        applyStimulus(0, 1'b1);
        drainOutputs(0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule

// File: doc/mat_mult_stream.md
Name: mat_mult_stream

Overview:
- Self-contained streaming rectangular matrix multiplier: C[M×N] = A[M×K] · B[K×N].
- Operands arrive element-serially on one valid/ready input stream; results leave element-serially on a valid/ready output stream, with row and frame markers.
- Successor to the square, fixed-size multiplier wrapper: independent M/K/N, true backpressure-safe output handshake, row markers, optional signed arithmetic.
- Sits between the DMA input stream and the result sink.

Parameters:
- M, 3, rows of A and of C.
- K, 3, columns of A = rows of B (inner dimension).
- N, 3, columns of B and of C; also the number of parallel MAC lanes.
- DATA_W, 4, operand width in bits.
- OUT_W, 2*DATA_W+$clog2(K)+1, result width (derived localparam, not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_data  in  DATA_W  operand element.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  OUT_W  result element C[i][j].
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts out_data.
- out_row_last  out  1  out_data is the last element of a C row (j==N-1).
- out_last  out  1  out_data is the last element of the frame (i==M-1, j==N-1).
- busy  out  1  high in any state other than LOAD_A, or while in LOAD_A with an element count above 0.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, out_row_last=0, out_last=0, busy=0. All counters cleared; state=LOAD_A. Operand buffers are not cleared.
- in_ready is registered. It goes to 1 the cycle after reset deasserts.
- Transfer rules:
  - An input beat transfers when in_valid && in_ready.
  - An output beat transfers when out_valid && out_ready.
- Input order: M*K elements of A, row-major, then K*N elements of B, row-major. No sideband framing; counts alone define boundaries.
- States:
  - LOAD_A: in_ready=1. Store A[r][c]. After the M*K-th beat, go to LOAD_B.
  - LOAD_B: in_ready=1. Store B[r][c]. After the K*N-th beat, go to COMPUTE with row i=0; in_ready drops the following cycle.
  - COMPUTE: in_ready=0. Accumulators acc[0..N-1] are cleared on entry. One k step per cycle, with all N lanes in parallel: acc[j] += A[i][k]*B[k][j]. Exactly K cycles, then go to OUTPUT.
  - OUTPUT: present acc[0..N-1] in order j=0..N-1.
    - out_valid asserts on the first OUTPUT cycle.
    - While out_valid && !out_ready, out_data, out_row_last and out_last hold stable.
    - After beat j=N-1: if i<M-1, increment i and go to COMPUTE. Otherwise go to LOAD_A.
    - out_valid deasserts the cycle after the final accepted beat unless another beat follows.
- Latency: the first out_valid appears K+1 cycles after the final B beat is accepted. Rows are not overlapped; per-row cost is K compute cycles plus N output beats (more under backpressure).
- Arithmetic (default): unsigned. Products are 2*DATA_W bits, zero-extended to OUT_W. No overflow is possible at OUT_W.
- Boundary conditions:
  - in_valid gaps in LOAD_A/LOAD_B stall loading without losing count.
  - in_valid asserted outside the LOAD states is ignored, because in_ready=0.
  - out_ready may be held high permanently; this gives one beat per cycle.
  - out_ready asserted while out_valid=0 has no effect.
  - M, K or N equal to 1 are legal: single-cycle COMPUTE, single-beat rows, out_row_last every beat when N=1.
  - A new frame's A elements are accepted only after returning to LOAD_A; there is no preloading.
- rst mid-operation, in any state: next cycle all outputs return to their reset values and state=LOAD_A. Partial input and partial results are discarded.

Optional Feature:
- MAT_MULT_SIGNED_EN
  - Defined: operands are two's complement; products and accumulation are signed, and out_data is sign-extended two's complement at OUT_W.
  - Undefined: unsigned as described above.
  - Handshake, timing and all other behaviour are identical in both modes.

Test Plan:
- Defaults; A=identity, B=1..9 row-major, out_ready=1 → out_data 1..9 in order; out_row_last on beats 3, 6, 9; out_last only on beat 9; first out_valid exactly 4 cycles after the last B beat.
- Defaults; all operands 15 → nine outputs of 675; no truncation at OUT_W=11.
- M=2, K=4, N=1; A=[1 2 3 4; 5 6 7 8], B=[1 1 1 1]ᵀ → outputs 10, 26; out_row_last on both beats; out_last on the second.
- Defaults, identity×(1..9), out_ready toggling 1-0-0-1 and random in_valid gaps → same 9 values; out_data, out_row_last and out_last stable across every stalled cycle; no beat lost or duplicated.
- rst pulsed during OUTPUT after 4 beats → next cycle out_valid=0, in_ready=0, busy=0, then in_ready=1; a fresh frame produces correct results.
- MAT_MULT_SIGNED_EN, defaults; A all 4'h8 (−8), B all 4'hF (−1) → all outputs +24; A all −8, B all −8 → all outputs +192 (11'h0C0).
